// File: rtl/bus_bridge_master_ctrl_pkg.sv
// Shared definitions for the UART bus bridge (master side): FSM state
// encodings, transfer mode constants and frame-width helper.
package bus_bridge_master_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_RWAIT  = 3'd2,
    ST_TXSEND = 3'd3,
    ST_TXWAIT = 3'd4
  } state_t;

  localparam logic MODE_WR = 1'b1;
  localparam logic MODE_RD = 1'b0;

  // Frame layout: {mode, wdata, addr}
  function automatic int frame_w(input int data_w, input int addr_w);
    return data_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/bridge_cmd_fifo.sv
// Synchronous command FIFO with show-ahead head output. Pointers carry one
// extra wrap bit so full/empty are distinguished without a counter.
module bridge_cmd_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  // Pointer update; push and pop in the same cycle both take effect
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/bus_bridge_master_ctrl.sv
// Remote-side UART bus bridge controller: buffers command frames from the
// UART RX link and replays them one at a time on the local master port,
// returning read data on the UART TX link.
// Optional build macro BRIDGE_RD_TIMEOUT_EN: read wait gives up after
// RD_TIMEOUT cycles and returns all-ones so the requester is never starved.
module bus_bridge_master_ctrl
  import bus_bridge_master_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 4096
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [DATA_WIDTH+ADDR_WIDTH:0]   u_rx_data,
  input  logic                             u_rx_ready,
  output logic [DATA_WIDTH-1:0]            u_tx_data,
  output logic                             u_tx_en,
  input  logic                             u_tx_busy,
  output logic                             m_req,
  output logic                             m_mode,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic                             m_ack,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  logic                             m_rvalid,
  output logic                             ovf
);

  localparam int FRAME_W   = frame_w(DATA_WIDTH, ADDR_WIDTH);
  localparam int MODE_BIT  = FRAME_W - 1;
  localparam int WDATA_LSB = ADDR_WIDTH;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (RD_TIMEOUT < 1) begin : g_bad_timeout
    $error("RD_TIMEOUT must be at least 1");
  end

  state_t               state;
  state_t               state_nxt;
  logic                 u_rx_ready_d;
  logic                 rx_pulse;
  logic [FRAME_W-1:0]   frame_p1;
  logic                 vld_p1;
  logic [FRAME_W-1:0]   fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 cap_rd;
  logic                 cap_to;
  logic                 tx_fire;
  logic                 busy_seen;
  logic                 rd_timeout;

  assign rx_pulse = u_rx_ready && !u_rx_ready_d;

  // Ingress edge detect (p0) and frame capture into the push stage (p1)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      u_rx_ready_d <= 1'b0;
      vld_p1       <= 1'b0;
    end else begin
      u_rx_ready_d <= u_rx_ready;
      vld_p1       <= rx_pulse;
    end
  end

  // Frame payload follows the valid pulse; no reset needed on data
  always_ff @(posedge clk) begin
    if (rx_pulse) frame_p1 <= u_rx_data;
  end

  bridge_cmd_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (vld_p1),
    .din   (frame_p1),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef BRIDGE_RD_TIMEOUT_EN
  localparam int              TO_W    = $clog2(RD_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;

  // Read-wait cycle counter, cleared whenever the FSM leaves RWAIT
  always_ff @(posedge clk) begin
    if (!rstn)                  to_cnt <= '0;
    else if (state == ST_RWAIT) to_cnt <= to_cnt + 1'b1;
    else                        to_cnt <= '0;
  end

  assign rd_timeout = (state == ST_RWAIT) && (to_cnt == TO_LAST);
`else
  assign rd_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state and one-cycle control strobes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap_rd    = 1'b0;
    cap_to    = 1'b0;
    tx_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_ack) begin
          if (m_mode == MODE_WR) begin
            state_nxt = ST_IDLE;
          end else if (m_rvalid) begin
            cap_rd    = 1'b1;
            state_nxt = ST_TXSEND;
          end else begin
            state_nxt = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        if (m_rvalid) begin
          cap_rd    = 1'b1;
          state_nxt = ST_TXSEND;
        end else if (rd_timeout) begin
          cap_to    = 1'b1;
          state_nxt = ST_TXSEND;
        end
      end
      ST_TXSEND: begin
        if (!u_tx_busy) begin
          tx_fire   = 1'b1;
          state_nxt = ST_TXWAIT;
        end
      end
      ST_TXWAIT: begin
        if (busy_seen && !u_tx_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Master-port and UART TX output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_req     <= 1'b0;
      m_mode    <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      u_tx_data <= '0;
      u_tx_en   <= 1'b0;
    end else begin
      if (pop) begin
        m_req   <= 1'b1;
        m_mode  <= fifo_dout[MODE_BIT];
        m_addr  <= fifo_dout[ADDR_WIDTH-1:0];
        m_wdata <= fifo_dout[WDATA_LSB +: DATA_WIDTH];
      end else if (state == ST_ISSUE && m_ack) begin
        m_req <= 1'b0;
      end
      if (cap_rd)      u_tx_data <= m_rdata;
      else if (cap_to) u_tx_data <= '1;
      u_tx_en <= tx_fire;
    end
  end

  // TX completion tracking: busy must be seen high before its fall counts
  always_ff @(posedge clk) begin
    if (!rstn)                        busy_seen <= 1'b0;
    else if (state != ST_TXWAIT)      busy_seen <= 1'b0;
    else if (u_tx_busy)               busy_seen <= 1'b1;
  end

  // Sticky overflow flag: a frame arrived while the FIFO was full
  always_ff @(posedge clk) begin
    if (!rstn)                    ovf <= 1'b0;
    else if (vld_p1 && fifo_full) ovf <= 1'b1;
  end

endmodule

// File: tb/tb_bus_bridge_master_ctrl.sv
// Self-checking bench for bus_bridge_master_ctrl: table of single
// transactions plus hand-written sequences for busy TX, FIFO order/full,
// reset mid-transaction and (when enabled) the read timeout.
module tb_bus_bridge_master_ctrl;

  logic        clk;
  logic        rstn;
  logic [20:0] u_rx_data;
  logic        u_rx_ready;
  logic [7:0]  u_tx_data;
  logic        u_tx_en;
  logic        u_tx_busy;
  logic        m_req;
  logic        m_mode;
  logic [11:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_ack;
  logic [7:0]  m_rdata;
  logic        m_rvalid;
  logic        ovf;

  int n_tests;
  int n_fail;
  int tx_pulses;

  bus_bridge_master_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (12),
    .FIFO_DEPTH (4),
    .RD_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .u_rx_data  (u_rx_data),
    .u_rx_ready (u_rx_ready),
    .u_tx_data  (u_tx_data),
    .u_tx_en    (u_tx_en),
    .u_tx_busy  (u_tx_busy),
    .m_req      (m_req),
    .m_mode     (m_mode),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_rdata    (m_rdata),
    .m_rvalid   (m_rvalid),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (u_tx_en) tx_pulses <= tx_pulses + 1;
  end

  typedef struct {
    logic        mode;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          rv_dly;
    logic        exp_mode;
    logic [11:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_tx;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic mode, input logic [11:0] addr, input logic [7:0] wd);
    @(negedge clk);
    u_rx_data  = {mode, wd, addr};
    u_rx_ready = 1'b1;
    @(negedge clk);
    u_rx_ready = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!m_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", m_req, 1'b1);
  endtask

  task automatic ack_txn(input logic rv_same, input logic [7:0] rd);
    m_ack = 1'b1;
    if (rv_same) begin
      m_rvalid = 1'b1;
      m_rdata  = rd;
    end
    @(negedge clk);
    m_ack    = 1'b0;
    m_rvalid = 1'b0;
    chk("req_drop_after_ack", m_req, 1'b0);
  endtask

  task automatic wait_tx_en(output int n);
    n = 0;
    while (!u_tx_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_en_seen", u_tx_en, 1'b1);
  endtask

  task automatic finish_tx();
    u_tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    u_tx_busy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"},     m_req,     1'b0);
    chk({tag, "_m_mode"},    m_mode,    1'b0);
    chk({tag, "_m_addr"},    m_addr,    12'h000);
    chk({tag, "_m_wdata"},   m_wdata,   8'h00);
    chk({tag, "_u_tx_data"}, u_tx_data, 8'h00);
    chk({tag, "_u_tx_en"},   u_tx_en,   1'b0);
    chk({tag, "_ovf"},       ovf,       1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    int   p0;
    logic [7:0] last_tx;
    logic req_seen;

    clk = 0; rstn = 0; u_rx_data = '0; u_rx_ready = 0; u_tx_busy = 0;
    m_ack = 0; m_rdata = '0; m_rvalid = 0;
    n_tests = 0; n_fail = 0; tx_pulses = 0;

    //            mode addr    wd     rd     dly  emode eaddr   ewd    etx    pulses
    vecs[0] = '{1'b1, 12'h123, 8'hA5, 8'h00, 0, 1'b1, 12'h123, 8'hA5, 8'h00, 0};
    vecs[1] = '{1'b0, 12'h7FF, 8'h00, 8'h3C, 5, 1'b0, 12'h7FF, 8'h00, 8'h3C, 1};
    vecs[2] = '{1'b1, 12'hFFF, 8'h00, 8'h00, 0, 1'b1, 12'hFFF, 8'h00, 8'h3C, 0};
    vecs[3] = '{1'b0, 12'h000, 8'h00, 8'hFF, 0, 1'b0, 12'h000, 8'h00, 8'hFF, 1};
    vecs[4] = '{1'b0, 12'h555, 8'h00, 8'h00, 1, 1'b0, 12'h555, 8'h00, 8'h00, 1};
    vecs[5] = '{1'b1, 12'hABC, 8'h5A, 8'h00, 0, 1'b1, 12'hABC, 8'h5A, 8'h00, 0};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1;
    repeat (2) @(negedge clk);
    chk("idle_no_req", m_req, 1'b0);

    // Table-driven single transactions
    last_tx = 8'h00;
    for (int i = 0; i < 6; i++) begin
      p0 = tx_pulses;
      send_frame(vecs[i].mode, vecs[i].addr, vecs[i].wdata);
      wait_req();
      chk($sformatf("v%0d_mode", i),  m_mode,  vecs[i].exp_mode);
      chk($sformatf("v%0d_addr", i),  m_addr,  vecs[i].exp_addr);
      chk($sformatf("v%0d_wdata", i), m_wdata, vecs[i].exp_wdata);
      if (vecs[i].mode == 1'b0) begin
        if (vecs[i].rv_dly == 0) begin
          ack_txn(1'b1, vecs[i].rdata);
        end else begin
          ack_txn(1'b0, 8'h00);
          repeat (vecs[i].rv_dly - 1) @(negedge clk);
          m_rdata  = vecs[i].rdata;
          m_rvalid = 1'b1;
          @(negedge clk);
          m_rvalid = 1'b0;
        end
        wait_tx_en(n);
        chk($sformatf("v%0d_tx_data", i), u_tx_data, vecs[i].exp_tx);
        finish_tx();
        last_tx = vecs[i].exp_tx;
      end else begin
        ack_txn(1'b0, 8'h00);
        repeat (5) @(negedge clk);
        chk($sformatf("v%0d_tx_hold", i), u_tx_data, vecs[i].exp_tx);
      end
      chk($sformatf("v%0d_pulses", i), tx_pulses - p0, vecs[i].exp_pulses);
    end

    // Busy TX: strobe must wait for busy to fall, then fire once
    p0 = tx_pulses;
    send_frame(1'b0, 12'h0AA, 8'h00);
    wait_req();
    u_tx_busy = 1'b1;
    ack_txn(1'b0, 8'h00);
    @(negedge clk);
    m_rdata = 8'h96; m_rvalid = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_no_tx_en", u_tx_en, 1'b0);
    chk("busy_no_pulse", tx_pulses - p0, 0);
    chk("busy_tx_data", u_tx_data, 8'h96);
    u_tx_busy = 1'b0;
    wait_tx_en(n);
    finish_tx();
    chk("busy_pulses", tx_pulses - p0, 1);

    // FIFO order and full: ack withheld while 6 frames arrive
    for (int k = 0; k < 5; k++) send_frame(1'b1, 12'h101 + 12'(k), 8'h11 + 8'(k));
    repeat (3) @(negedge clk);
    chk("full_ovf_clear", ovf, 1'b0);
    chk("full_head_req", m_req, 1'b1);
    chk("full_head_addr", m_addr, 12'h101);
    send_frame(1'b1, 12'h106, 8'h16);
    repeat (3) @(negedge clk);
    chk("full_ovf_set", ovf, 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_req();
      chk($sformatf("order%0d_addr", k),  m_addr,  12'h101 + 12'(k));
      chk($sformatf("order%0d_wdata", k), m_wdata, 8'h11 + 8'(k));
      ack_txn(1'b0, 8'h00);
      if (k == 0) begin
        @(negedge clk);
        chk("b2b_req_next", m_req, 1'b1);
      end
    end
    req_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (m_req) req_seen = 1'b1;
    end
    chk("dropped_not_run", req_seen, 1'b0);

    // Reset in RWAIT with two frames queued
    send_frame(1'b0, 12'h321, 8'h00);
    wait_req();
    ack_txn(1'b0, 8'h00);
    send_frame(1'b1, 12'h222, 8'h22);
    send_frame(1'b1, 12'h333, 8'h33);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    req_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (m_req || u_tx_en) req_seen = 1'b1;
    end
    chk("post_rst_idle", req_seen, 1'b0);

`ifdef BRIDGE_RD_TIMEOUT_EN
    // Read timeout: no m_rvalid, all-ones returned after 16 RWAIT cycles
    p0 = tx_pulses;
    send_frame(1'b0, 12'h0F0, 8'h00);
    wait_req();
    ack_txn(1'b0, 8'h00);
    wait_tx_en(n);
    chk("to_latency", n, 17);
    chk("to_tx_data", u_tx_data, 8'hFF);
    finish_tx();
    chk("to_pulses", tx_pulses - p0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
